memory_arbiter: RTL

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_pkg.sv | 15 +
 rtl/memory_arbiter_if.sv | 22 ++
 rtl/bus_watchdog.sv | 30 +++
 rtl/memory_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encodings and bus
// direction / lane constants.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DATA        = 2'd1,
        INSTRUCTION = 2'd2
    } arbiter_state_t;

    localparam logic       READ       = 1'b0;
    localparam logic       WRITE      = 1'b1;
    localparam logic [3:0] SELECT_ALL = 4'b1111;

endpackage

// File: rtl/memory_arbiter_if.sv
// Memory-side bus between the arbiter (master) and the memory (slave).
interface memory_arbiter_if;

    logic        bus_request;
    logic        bus_write;
    logic [31:0] bus_address;
    logic [3:0]  bus_select;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data;
    logic        bus_acknowledge;

    modport master (
        output bus_request, bus_write, bus_address, bus_select, bus_write_data,
        input  bus_read_data, bus_acknowledge
    );

    modport slave (
        input  bus_request, bus_write, bus_address, bus_select, bus_write_data,
        output bus_read_data, bus_acknowledge
    );

endinterface

// File: rtl/bus_watchdog.sv
// Busy-cycle counter that flags the last permitted cycle of an unanswered
// bus transaction.
module bus_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_enable,
    output logic limit_reached
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (count_enable) begin
            count <= count + 8'd1;
        end
    end

    // Fires during the LIMIT-th unanswered cycle so the abort lands on its closing edge.
    assign limit_reached = count_enable && (count == LAST);

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates instruction fetches and data loads/stores onto one memory bus,
// data side first, with a watchdog abort for unanswered transactions.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int WATCHDOG_LIMIT = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    instruction_read_enable,
    input  logic [31:0]             instruction_read_address,
    output logic [31:0]             instruction_read_data,
    output logic                    instruction_ready,
    input  logic                    data_read_enable,
    input  logic                    data_write_enable,
    input  logic [31:0]             data_read_address,
    input  logic [31:0]             data_write_address,
    input  logic [3:0]              data_write_select,
    input  logic [31:0]             data_write_data,
    output logic [31:0]             data_read_data,
    output logic                    data_ready,
    output logic                    stall_request,
    output logic                    bus_error,
    memory_arbiter_if.master        bus
);

    arbiter_state_t state, state_next;

    logic        bus_write_r;
    logic [31:0] bus_address_r;
    logic [3:0]  bus_select_r;
    logic [31:0] bus_write_data_r;

    logic busy, acknowledged, limit_reached, transaction_done;
    logic data_pending, fetch_pending;

    // A requester whose ready pulse is showing has just been served; do not re-issue it.
    assign data_pending     = (data_read_enable || data_write_enable) && !data_ready;
    assign fetch_pending    = instruction_read_enable && !instruction_ready;
    assign busy             = (state != IDLE);
    assign acknowledged     = busy && bus.bus_acknowledge;
    assign transaction_done = acknowledged || limit_reached;

    bus_watchdog #(
        .LIMIT(WATCHDOG_LIMIT)
    ) watchdog (
        .clock        (clock),
        .reset        (reset),
        .clear        (!busy),
        .count_enable (busy && !bus.bus_acknowledge),
        .limit_reached(limit_reached)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (data_pending) begin
                    state_next = DATA;
                end else if (fetch_pending) begin
                    state_next = INSTRUCTION;
                end
            end
            DATA, INSTRUCTION: begin
                if (transaction_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus fields are latched once at acceptance and held until the transaction ends.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_write_r      <= READ;
            bus_address_r    <= 32'd0;
            bus_select_r     <= 4'd0;
            bus_write_data_r <= 32'd0;
        end else if (state == IDLE) begin
            if (data_pending) begin
                if (data_write_enable) begin
                    bus_write_r      <= WRITE;
                    bus_address_r    <= data_write_address;
                    bus_select_r     <= data_write_select;
                    bus_write_data_r <= data_write_data;
                end else begin
                    bus_write_r      <= READ;
                    bus_address_r    <= data_read_address;
                    bus_select_r     <= SELECT_ALL;
                    bus_write_data_r <= 32'd0;
                end
            end else if (fetch_pending) begin
                bus_write_r      <= READ;
                bus_address_r    <= instruction_read_address;
                bus_select_r     <= SELECT_ALL;
                bus_write_data_r <= 32'd0;
            end
        end
    end

    // An aborted read returns zero so the requester never sees stale data as fresh.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instruction_ready     <= 1'b0;
            data_ready            <= 1'b0;
            instruction_read_data <= 32'd0;
            data_read_data        <= 32'd0;
            bus_error             <= 1'b0;
        end else begin
            instruction_ready <= (state == INSTRUCTION) && transaction_done;
            data_ready        <= (state == DATA) && transaction_done;
            if ((state == INSTRUCTION) && transaction_done) begin
                instruction_read_data <= acknowledged ? bus.bus_read_data : 32'd0;
            end
            if ((state == DATA) && transaction_done && (bus_write_r == READ)) begin
                data_read_data <= acknowledged ? bus.bus_read_data : 32'd0;
            end
            if (limit_reached) begin
                bus_error <= 1'b1;
            end
        end
    end

    assign stall_request = !reset &&
                           ((instruction_read_enable && !instruction_ready) ||
                            ((data_read_enable || data_write_enable) && !data_ready));

    assign bus.bus_request    = busy;
    assign bus.bus_write      = bus_write_r;
    assign bus.bus_address    = bus_address_r;
    assign bus.bus_select     = bus_select_r;
    assign bus.bus_write_data = bus_write_data_r;

endmodule
